infrared_rx_fifo: RTL



---
 rtl/infrared_rx_fifo.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/infrared_rx_fifo.sv
// NEC infrared receiver: 2-FF synchronised input, 10 us tick duration measurement,
// frame/repeat decoding into a FIFO drained through a four-register slave port.
//
// state    | meaning
// IDLE     | waiting for the falling edge of a leader burst
// LEAD_L   | timing the 9 ms leader low
// LEAD_H   | timing the leader space (4.5 ms frame / 2.25 ms repeat)
// BIT_L    | timing the 560 us low that precedes every data bit
// BIT_H    | timing the data space; its length selects 0 or 1
// DONE     | one cycle: command check, push and latch of last_code
// REPEAT   | one cycle: optional push of last_code with the repeat flag
module infrared_rx_fifo #(
   parameter int CLK_HZ     = 50000000,
   parameter int FIFO_DEPTH = 8,
   parameter int CHECK_INV  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ir,
   input  logic        s_cs_n,
   input  logic [1:0]  s_address,
   input  logic        s_read,
   output logic [31:0] s_readdata,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic        irq
);

   localparam int DIV = (CLK_HZ / 100000 < 1) ? 1 : CLK_HZ / 100000;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_LEAD_L, ST_LEAD_H, ST_BIT_L, ST_BIT_H, ST_DONE, ST_REPEAT
   } state_t;

   logic [1:0]    sync_q;
   logic          ir_prev_q;
   logic [PW-1:0] presc_q;
   logic [9:0]    dur_q;
   logic          tick, fall, rise, timeout;

   state_t        state_q;
   logic [31:0]   code_q;
   logic [4:0]    bit_cnt_q;
   logic [31:0]   last_code_q;
   logic          last_vld_q;
   logic          push_q;
   logic [32:0]   push_data_q;
   logic          err_set_q;

   logic [32:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          err_q, err_d, ovf_q, ovf_d;
   logic          irq_en_q, irq_en_d, rpt_en_q, rpt_en_d;
   logic          irq_q, irq_d;

   logic          sel, wr_status, wr_ctrl, flush, pop, full, not_empty;
   logic          do_push, ovf_set;
   logic [32:0]   head;
   logic          unused_wdata;

   function automatic logic in_rng(input logic [9:0] d, input int lo, input int hi);
      int dv;
      dv = int'(d);
      return (dv >= lo) && (dv <= hi);
   endfunction

   assign tick    = (presc_q == '0);
   assign fall    = ir_prev_q & ~sync_q[1];
   assign rise    = ~ir_prev_q & sync_q[1];
   assign timeout = sync_q[1] && (dur_q > 10'd1000);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q    <= 2'b11;
         ir_prev_q <= 1'b1;
         presc_q   <= '0;
         dur_q     <= '0;
      end else begin
         sync_q    <= {sync_q[0], ir};
         ir_prev_q <= sync_q[1];
         presc_q   <= tick ? PW'(DIV - 1) : presc_q - 1'b1;
         if (rise || fall)
            dur_q <= '0;
         else if (tick && dur_q != 10'h3FF)
            dur_q <= dur_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         code_q      <= '0;
         bit_cnt_q   <= '0;
         last_code_q <= '0;
         last_vld_q  <= 1'b0;
         push_q      <= 1'b0;
         push_data_q <= '0;
         err_set_q   <= 1'b0;
      end else begin
         push_q    <= 1'b0;
         err_set_q <= 1'b0;
         case (state_q)
            ST_IDLE:
               if (fall) state_q <= ST_LEAD_L;
            ST_LEAD_L:
               if (rise) begin
                  if (in_rng(dur_q, 800, 1000)) state_q <= ST_LEAD_H;
                  else begin state_q <= ST_IDLE; err_set_q <= 1'b1; end
               end
            ST_LEAD_H:
               if (fall) begin
                  if (in_rng(dur_q, 400, 500)) begin
                     state_q   <= ST_BIT_L;
                     bit_cnt_q <= '0;
                  end else if (in_rng(dur_q, 200, 250)) begin
                     state_q <= ST_REPEAT;
                  end else begin
                     state_q <= ST_IDLE; err_set_q <= 1'b1;
                  end
               end else if (timeout) begin
                  state_q <= ST_IDLE;
               end
            ST_BIT_L:
               if (rise) begin
                  if (in_rng(dur_q, 40, 70)) state_q <= ST_BIT_H;
                  else begin state_q <= ST_IDLE; err_set_q <= 1'b1; end
               end
            ST_BIT_H:
               if (fall) begin
                  if (in_rng(dur_q, 40, 70) || in_rng(dur_q, 140, 190)) begin
                     code_q    <= {in_rng(dur_q, 140, 190), code_q[31:1]};
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     state_q   <= (bit_cnt_q == 5'd31) ? ST_DONE : ST_BIT_L;
                  end else begin
                     state_q <= ST_IDLE; err_set_q <= 1'b1;
                  end
               end else if (timeout) begin
                  state_q <= ST_IDLE;
               end
            ST_DONE: begin
               if (CHECK_INV == 0 || code_q[23:16] == ~code_q[31:24]) begin
                  push_q      <= 1'b1;
                  push_data_q <= {1'b0, code_q};
                  last_code_q <= code_q;
                  last_vld_q  <= 1'b1;
               end else begin
                  err_set_q <= 1'b1;
               end
               state_q <= ST_IDLE;
            end
            ST_REPEAT: begin
               if (rpt_en_q && last_vld_q) begin
                  push_q      <= 1'b1;
                  push_data_q <= {1'b1, last_code_q};
               end
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sel          = ~s_cs_n;
   assign wr_status    = sel & s_write & (s_address == 2'd1);
   assign wr_ctrl      = sel & s_write & (s_address == 2'd2);
   assign flush        = wr_ctrl & s_writedata[2];
   assign not_empty    = (cnt_q != '0);
   assign full         = (cnt_q == (AW + 1)'(FIFO_DEPTH));
   assign pop          = sel & s_read & (s_address == 2'd0) & not_empty;
   // a pop frees the slot the simultaneous push needs, so a full FIFO still accepts it
   assign do_push      = push_q & ~flush & (~full | pop);
   assign ovf_set      = push_q & ~flush & full & ~pop;
   assign head         = mem_q[rd_ptr_q];
   assign unused_wdata = ^{s_writedata[31], s_writedata[28:3]};

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
         case ({do_push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
      err_d    = (err_q & ~(wr_status & s_writedata[29])) | err_set_q;
      ovf_d    = (ovf_q & ~(wr_status & s_writedata[30])) | ovf_set;
      irq_en_d = wr_ctrl ? s_writedata[0] : irq_en_q;
      rpt_en_d = wr_ctrl ? s_writedata[1] : rpt_en_q;
      irq_d    = irq_en_q & (not_empty | ovf_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         rpt_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         rpt_en_q <= rpt_en_d;
         irq_q    <= irq_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_q;
   end

   always_comb begin
      s_readdata = '0;
      case (s_address)
         2'd0:    s_readdata = not_empty ? head[31:0] : 32'd0;
         2'd1:    s_readdata = {not_empty, ovf_q, err_q, not_empty & head[32], 20'd0, 8'(cnt_q)};
         2'd2:    s_readdata = {30'd0, rpt_en_q, irq_en_q};
         default: s_readdata = '0;
      endcase
   end

   assign irq = irq_q;

endmodule
